// File: rtl/cpu_probe_pkg.sv
// cpu_probe_pkg: shared definitions for the pipeline_cpu probe scanner.
//   KIND_*  : record kind codes carried on out_kind
//   state_t : scanner FSM states
//   phase_t : which location class is being swept
//   rec_t   : one output record {kind, addr, data}; REC_W is its width
package cpu_probe_pkg;

   localparam logic [1:0] KIND_RF  = 2'd0;
   localparam logic [1:0] KIND_MEM = 2'd1;
   localparam logic [1:0] KIND_PC  = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_t;
   typedef enum logic [1:0] {PH_RF, PH_MEM, PH_PC} phase_t;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } rec_t;

   localparam int unsigned REC_W = $bits(rec_t);

endpackage

// File: rtl/probe_out_slot.sv
// probe_out_slot: single valid/ready holding register for scanner records.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_rec and raise o_valid
//   i_clear        : drop o_valid (record discarded), highest priority
//   i_ready        : downstream accepts; o_valid falls after a handshake
//   i_rec / o_rec  : record in / held record out
//   o_valid        : record valid
module probe_out_slot
   import cpu_probe_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_ready,
   input  logic [REC_W-1:0] i_rec,
   output logic             o_valid,
   output logic [REC_W-1:0] o_rec
);

   logic             r_valid;
   logic [REC_W-1:0] r_rec;

   // Load wins over a same-cycle handshake so back-to-back records never bubble.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_rec   <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_rec   <= i_rec;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_rec   = r_rec;

endmodule

// File: rtl/cpu_probe_scanner.sv
// cpu_probe_scanner: sweeps pipeline_cpu's 32 GPRs, then a MEM_WORDS-word data
// memory window, through the probe ports and streams one record per location.
//   clk, resetn           : clock, asynchronous active-low reset
//   start / abort         : begin scan (IDLE only) / cancel scan (non-IDLE only)
//   busy / done           : scan in progress / one-cycle completion pulse
//   rf_addr, rf_data      : register-file probe address out, data in
//   mem_addr, mem_data    : data-memory probe byte address out, data in
//   IF_pc..WB_pc          : stage PCs, snapshotted on start with PROBE_PC_SNAP_EN
//   out_valid/out_ready   : record stream handshake
//   out_kind/addr/data    : record fields
// Optional feature macro: PROBE_PC_SNAP_EN (appends 5 stage-PC records).
module cpu_probe_scanner
   import cpu_probe_pkg::*;
#(
   parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 16,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic [31:0] IF_pc,
   input  logic [31:0] ID_pc,
   input  logic [31:0] EXE_pc,
   input  logic [31:0] MEM_pc,
   input  logic [31:0] WB_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_kind,
   output logic [31:0] out_addr,
   output logic [31:0] out_data
);

   localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);
   localparam logic [1:0] WAIT_END = 2'(READ_LAT);

   state_t      r_state, w_state_nx;
   phase_t      r_phase, w_phase_nx;
   logic [7:0]  r_idx, w_idx_nx;
   logic [1:0]  r_wait, w_wait_nx;
   logic [4:0]  r_rf_addr, w_rf_addr_nx;
   logic [31:0] r_mem_addr, w_mem_addr_nx;
   logic        r_busy, w_busy_nx;
   logic        r_done, w_done_nx;
   logic        w_load, w_clear, w_hs, w_slot_valid;
   rec_t        w_rec, w_slot_rec;

`ifdef PROBE_PC_SNAP_EN
   logic [31:0] r_pc [5];
   logic [31:0] w_pc_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < 5; i++) r_pc[i] <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_pc[0] <= IF_pc;
         r_pc[1] <= ID_pc;
         r_pc[2] <= EXE_pc;
         r_pc[3] <= MEM_pc;
         r_pc[4] <= WB_pc;
      end
   end

   // PC record following the one currently indexed by r_idx.
   always_comb begin
      case (r_idx[2:0])
         3'd0:    w_pc_next = r_pc[1];
         3'd1:    w_pc_next = r_pc[2];
         3'd2:    w_pc_next = r_pc[3];
         default: w_pc_next = r_pc[4];
      endcase
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^{IF_pc, ID_pc, EXE_pc, MEM_pc, WB_pc};
`endif

   assign w_hs = w_slot_valid && out_ready;

   always_comb begin
      w_state_nx    = r_state;
      w_phase_nx    = r_phase;
      w_idx_nx      = r_idx;
      w_wait_nx     = r_wait;
      w_rf_addr_nx  = r_rf_addr;
      w_mem_addr_nx = r_mem_addr;
      w_busy_nx     = r_busy;
      w_done_nx     = 1'b0;
      w_load        = 1'b0;
      w_clear       = 1'b0;
      w_rec         = '0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx   = S_WAIT;
               w_phase_nx   = PH_RF;
               w_idx_nx     = '0;
               w_wait_nx    = '0;
               w_rf_addr_nx = '0;
               w_busy_nx    = 1'b1;
            end
         end
         S_WAIT: begin
            if (r_wait == WAIT_END) begin
               w_load     = 1'b1;
               w_state_nx = S_EMIT;
               if (r_phase == PH_RF) begin
                  w_rec.kind = KIND_RF;
                  w_rec.addr = 32'(r_rf_addr);
                  w_rec.data = rf_data;
               end else begin
                  w_rec.kind = KIND_MEM;
                  w_rec.addr = r_mem_addr;
                  w_rec.data = mem_data;
               end
            end else begin
               w_wait_nx = r_wait + 2'd1;
            end
         end
         S_EMIT: begin
            if (w_hs) begin
               w_state_nx = S_WAIT;
               w_wait_nx  = '0;
               case (r_phase)
                  PH_RF: begin
                     if (r_idx == 8'd31) begin
                        w_phase_nx    = PH_MEM;
                        w_idx_nx      = '0;
                        w_mem_addr_nx = MEM_BASE;
                     end else begin
                        w_idx_nx     = r_idx + 8'd1;
                        w_rf_addr_nx = r_rf_addr + 5'd1;
                     end
                  end
                  PH_MEM: begin
                     if (r_idx == LAST_MEM) begin
`ifdef PROBE_PC_SNAP_EN
                        // PC records come from local registers, so load straight into EMIT.
                        w_phase_nx = PH_PC;
                        w_idx_nx   = '0;
                        w_state_nx = S_EMIT;
                        w_load     = 1'b1;
                        w_rec.kind = KIND_PC;
                        w_rec.addr = '0;
                        w_rec.data = r_pc[0];
`else
                        w_state_nx = S_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
`endif
                     end else begin
                        w_idx_nx      = r_idx + 8'd1;
                        w_mem_addr_nx = r_mem_addr + 32'd4;
                     end
                  end
`ifdef PROBE_PC_SNAP_EN
                  PH_PC: begin
                     if (r_idx == 8'd4) begin
                        w_state_nx = S_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                     end else begin
                        w_idx_nx   = r_idx + 8'd1;
                        w_state_nx = S_EMIT;
                        w_load     = 1'b1;
                        w_rec.kind = KIND_PC;
                        w_rec.addr = 32'(r_idx + 8'd1);
                        w_rec.data = w_pc_next;
                     end
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase

      // Abort overrides everything, including a same-cycle handshake; probe addresses hold.
      if (r_state != S_IDLE && abort) begin
         w_state_nx    = S_IDLE;
         w_clear       = 1'b1;
         w_load        = 1'b0;
         w_busy_nx     = 1'b0;
         w_done_nx     = 1'b0;
         w_rf_addr_nx  = r_rf_addr;
         w_mem_addr_nx = r_mem_addr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_phase    <= PH_RF;
         r_idx      <= '0;
         r_wait     <= '0;
         r_rf_addr  <= '0;
         r_mem_addr <= MEM_BASE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_phase    <= w_phase_nx;
         r_idx      <= w_idx_nx;
         r_wait     <= w_wait_nx;
         r_rf_addr  <= w_rf_addr_nx;
         r_mem_addr <= w_mem_addr_nx;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
      end
   end

   probe_out_slot u_slot (
      .i_clk   (clk),
      .i_rst_n (resetn),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_ready (out_ready),
      .i_rec   (w_rec),
      .o_valid (w_slot_valid),
      .o_rec   (w_slot_rec)
   );

   assign busy      = r_busy;
   assign done      = r_done;
   assign rf_addr   = r_rf_addr;
   assign mem_addr  = r_mem_addr;
   assign out_valid = w_slot_valid;
   assign out_kind  = w_slot_rec.kind;
   assign out_addr  = w_slot_rec.addr;
   assign out_data  = w_slot_rec.data;

endmodule
